// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Holds the fetch PC, issues word reads to instruction memory over a
// request/grant bus, buffers in-order read responses in a prefetch FIFO and
// presents the head instruction to decode through a valid/ready handshake,
// already split into decode fields. A redirect flushes everything buffered
// and arranges for the responses still in flight to be dropped.
//
// Parameters:
//   DEPTH     prefetch FIFO entries; also the cap on buffered + outstanding
//             requests (power of two, >= 2)
//   RESET_PC  fetch address loaded at reset
//
// Ports:
//   clk, reset             clock (rising edge), async active-high reset
//   IMemReq/IMemAddr       read request valid / word-aligned byte address
//   IMemGnt                memory accepts the request this cycle
//   IMemRValid/IMemRData   in-order read response
//   Redirect/RedirectPC    flush and restart fetch at RedirectPC (bits [1:0]
//                          forced to 0)
//   InstrValid/InstrReady  head-instruction handshake with decode
//   Instr/InstrPC/PCPlus8  head instruction word, its address, address + 8
//   Op/Funct/Rd            Instr[27:26], Instr[25:20], Instr[15:12]

module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic [31:0] PCPlus8,
    output logic [1:0]  Op,
    output logic [5:0]  Funct,
    output logic [3:0]  Rd
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;   // counts 0..DEPTH
    localparam int unsigned SW = CW + 1;   // occupancy + outstanding

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // Architectural state
    logic [31:0] fetch_pc_q, fetch_pc_d;
    cnt_t        out_q,  out_d;     // requests granted, response not yet seen
    cnt_t        drop_q, drop_d;    // in-flight responses belonging to a flushed stream
    cnt_t        occ_q,  occ_d;     // prefetch FIFO occupancy
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        aq_rd_q,  aq_rd_d;
    ptr_t        aq_wr_q,  aq_wr_d;

    // Storage (no reset needed: every read is qualified by a count)
    logic [31:0] fifo_data_q [DEPTH];
    logic [31:0] fifo_pc_q   [DEPTH];
    logic [31:0] aq_pc_q     [DEPTH];   // address of each outstanding request

    logic        credit_ok;
    logic        req_fire;
    logic        resp_keep;
    logic        pop;
    logic [SW-1:0] used;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    always_comb begin
        used      = SW'(occ_q) + SW'(out_q);
        credit_ok = (used < SW'(DEPTH));
        // Redirect withdraws the request for its own cycle; the new PC is
        // requested from the next cycle on.
        IMemReq   = !reset && !Redirect && credit_ok;
        IMemAddr  = fetch_pc_q;
        req_fire  = IMemReq && IMemGnt;
    end

    // ------------------------------------------------------------------
    // Response / decode side
    // ------------------------------------------------------------------
    always_comb begin
        InstrValid = (occ_q != '0);
        // A response is buffered only if it belongs to the live stream and
        // no redirect is flushing in this same cycle.
        resp_keep  = IMemRValid && (drop_q == '0) && !Redirect;
        pop        = InstrValid && InstrReady && !Redirect;

        // Outputs read zero while the FIFO is empty so reset values are clean.
        Instr      = InstrValid ? fifo_data_q[rd_ptr_q] : '0;
        InstrPC    = InstrValid ? fifo_pc_q[rd_ptr_q]   : '0;
        PCPlus8    = InstrPC + 32'd8;
        Op         = Instr[27:26];
        Funct      = Instr[25:20];
        Rd         = Instr[15:12];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q + cnt_t'(req_fire) - cnt_t'(IMemRValid);
        drop_d     = drop_q;
        occ_d      = occ_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        aq_rd_d    = aq_rd_q;
        aq_wr_d    = aq_wr_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            aq_wr_d    = aq_wr_q + ptr_t'(1);
        end

        // The address queue tracks every in-flight request, dropped or not,
        // so it pops on every response.
        if (IMemRValid) begin
            aq_rd_d = aq_rd_q + ptr_t'(1);
        end

        if (Redirect) begin
            fetch_pc_d = {RedirectPC[31:2], 2'b00};
            occ_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Everything still in flight after this cycle belongs to the old
            // stream; any earlier drop count is subsumed by this value.
            drop_d     = out_d;
        end else begin
            if (IMemRValid && (drop_q != '0)) begin
                drop_d = drop_q - cnt_t'(1);
            end
            if (resp_keep) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            occ_d = occ_q + cnt_t'(resp_keep) - cnt_t'(pop);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            occ_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            aq_rd_q    <= '0;
            aq_wr_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            aq_rd_q    <= aq_rd_d;
            aq_wr_q    <= aq_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            aq_pc_q[aq_wr_q] <= fetch_pc_q;
        end
        if (resp_keep) begin
            fifo_data_q[wr_ptr_q] <= IMemRData;
            fifo_pc_q[wr_ptr_q]   <= aq_pc_q[aq_rd_q];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        reset;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRValid;
    logic [31:0] IMemRData;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic [31:0] PCPlus8;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rd;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemGnt    (IMemGnt),
        .IMemRValid (IMemRValid),
        .IMemRData  (IMemRData),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Instr      (Instr),
        .InstrPC    (InstrPC),
        .PCPlus8    (PCPlus8),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd)
    );

    always #5 clk = ~clk;   // posedge at 5, negedge at 10, ...

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } mresp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    mresp_t      mq[$];        // memory responses in flight
    exp_t        exp_q[$];     // scoreboard: instructions decode must see
    logic [31:0] got_pc[$];
    logic [31:0] gnt_addrs[$];
    int          got_cyc[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // stimulus controls
    logic        rst_ctl      = 1'b1;
    logic        redir_ctl    = 1'b0;
    logic        ready_ctl    = 1'b0;
    logic [31:0] redir_pc_ctl = '0;
    int          gnt_budget   = 0;
    int          lat          = 1;

    // reference state
    int          occ_m, out_m, drop_m;
    logic [31:0] pc_m;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a == 32'h0000_0200) ? 32'hE091_2003 : (a ^ 32'h0F00_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_q(input string name, input logic [31:0] a[$], input logic [31:0] e[$]);
        chk({name, " count"}, 32'(a.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < a.size(); i++) chk(name, a[i], e[i]);
    endtask

    task automatic clear_logs;
        got_pc.delete();
        gnt_addrs.delete();
        got_cyc.delete();
    endtask

    task automatic model_reset;
        occ_m  = 0;
        out_m  = 0;
        drop_m = 0;
        pc_m   = RST_PC;
        mq.delete();
        exp_q.delete();
    endtask

    // One clock cycle: drive at negedge, check at +1, advance model at +3.
    task automatic cycle;
        logic   fire, rv, pop_m;
        mresp_t m;
        @(negedge clk);
        cyc++;
        reset      = rst_ctl;
        Redirect   = redir_ctl;
        RedirectPC = redir_pc_ctl;
        InstrReady = ready_ctl;
        IMemGnt    = (gnt_budget > 0);
        if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
            IMemRValid = 1'b1;
            IMemRData  = mq[0].data;
        end else begin
            IMemRValid = 1'b0;
            IMemRData  = 32'hDEAD_BEEF;
        end
        #1;
        chk("IMemReq", 32'(IMemReq),
            32'(!reset && !Redirect && (occ_m + out_m < int'(DEPTH))));
        chk("InstrValid", 32'(InstrValid), 32'(occ_m > 0));
        chk("occupancy_le_depth", 32'(dut.occ_q <= DEPTH), 32'd1);
        fire = IMemReq && IMemGnt;
        if (fire) chk("IMemAddr", IMemAddr, pc_m);
        #2;
        rv    = IMemRValid;
        pop_m = (occ_m > 0) && InstrReady && !Redirect;
        if (reset) begin
            model_reset();
        end else begin
            if (fire) begin
                m.due  = cyc + lat;
                m.addr = IMemAddr;
                m.data = memword(IMemAddr);
                mq.push_back(m);
                gnt_addrs.push_back(IMemAddr);
                pc_m = pc_m + 32'd4;
                gnt_budget--;
                out_m++;
            end
            if (rv) begin
                chk("rvalid_has_outstanding", 32'(out_m > 0), 32'd1);
                m = mq.pop_front();
                out_m--;
            end
            if (Redirect) begin
                occ_m  = 0;
                drop_m = out_m;
                exp_q.delete();
                pc_m   = {redir_pc_ctl[31:2], 2'b00};
            end else begin
                if (rv) begin
                    if (drop_m > 0) drop_m--;
                    else begin
                        exp_q.push_back('{pc: m.addr, data: m.data});
                        occ_m++;
                    end
                end
                if (pop_m) occ_m--;
            end
        end
    endtask

    task automatic redirect_at(input logic [31:0] pc, input int budget);
        redir_ctl    = 1'b1;
        redir_pc_ctl = pc;
        cycle();
        redir_ctl    = 1'b0;
        gnt_budget   = budget;
    endtask

    // Monitor: every accepted instruction is popped from the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (!reset && InstrValid && InstrReady && !Redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc %h instr %h, none expected (cycle %0d)",
                         InstrPC, Instr, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("Instr",   Instr,   e.data);
                chk("InstrPC", InstrPC, e.pc);
                chk("PCPlus8", PCPlus8, e.pc + 32'd8);
                chk("Op",      32'(Op),    32'(e.data[27:26]));
                chk("Funct",   32'(Funct), 32'(e.data[25:20]));
                chk("Rd",      32'(Rd),    32'(e.data[15:12]));
            end
            got_pc.push_back(InstrPC);
            got_cyc.push_back(cyc);
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    initial begin : main
        int rel;
        reset = 1'b1; Redirect = 1'b0; RedirectPC = '0; InstrReady = 1'b0;
        IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = '0;
        model_reset();

        // ---- reset state ----
        repeat (3) cycle();
        chk("rst InstrValid", 32'(InstrValid), 32'd0);
        chk("rst IMemReq",    32'(IMemReq),    32'd0);
        chk("rst Instr",      Instr,           32'd0);
        chk("rst InstrPC",    InstrPC,         32'd0);
        chk("rst PCPlus8",    PCPlus8,         32'd8);
        chk("rst Op",         32'(Op),         32'd0);
        chk("rst Funct",      32'(Funct),      32'd0);
        chk("rst Rd",         32'(Rd),         32'd0);

        // ---- reset release, 1-cycle memory, one instr per cycle ----
        clear_logs(); lat = 1; ready_ctl = 1'b1; gnt_budget = 6; rst_ctl = 1'b0;
        cycle(); rel = cyc;
        repeat (11) cycle();
        chk_q("t1 grants", gnt_addrs, '{32'h8000, 32'h8004, 32'h8008, 32'h800C, 32'h8010, 32'h8014});
        chk_q("t1 pcs",    got_pc,    '{32'h8000, 32'h8004, 32'h8008, 32'h800C, 32'h8010, 32'h8014});
        for (int i = 0; i < got_cyc.size(); i++) chk("t1 pop cycle", 32'(got_cyc[i] - rel), 32'(2 + i));

        // ---- decode stalled: exactly DEPTH grants, then resume ----
        clear_logs(); ready_ctl = 1'b0;
        redirect_at(32'h0, 100);
        repeat (10) cycle();
        chk_q("t2 stalled grants", gnt_addrs, '{32'h0, 32'h4, 32'h8, 32'hC});
        chk("t2 req held low", 32'(IMemReq), 32'd0);
        chk("t2 head pc",      InstrPC,      32'h0);
        gnt_budget = 2; ready_ctl = 1'b1;
        repeat (10) cycle();
        chk_q("t2 grants", gnt_addrs, '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14});
        chk_q("t2 pcs",    got_pc,    '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14});

        // ---- decode fields ----
        clear_logs();
        redirect_at(32'h203, 1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (InstrValid) break;
        end
        chk("t3 valid seen", 32'(InstrValid), 32'd1);
        chk("t3 Instr",   Instr,         32'hE091_2003);
        chk("t3 InstrPC", InstrPC,       32'h200);
        chk("t3 PCPlus8", PCPlus8,       32'h208);
        chk("t3 Op",      32'(Op),       32'(2'b00));
        chk("t3 Funct",   32'(Funct),    32'(6'b001001));
        chk("t3 Rd",      32'(Rd),       32'h2);
        repeat (3) cycle();

        // ---- redirect with two requests outstanding (latency 3) ----
        lat = 3;
        redirect_at(32'h300, 2);
        cycle(); cycle();
        clear_logs();
        redirect_at(32'h101, 3);
        repeat (14) cycle();
        chk_q("t4 grants", gnt_addrs, '{32'h100, 32'h104, 32'h108});
        chk_q("t4 pcs",    got_pc,    '{32'h100, 32'h104, 32'h108});

        // ---- redirect coinciding with pop and response (latency 2) ----
        lat = 2; clear_logs();
        redirect_at(32'h500, 100);
        repeat (4) cycle();
        redirect_at(32'h600, 3);
        repeat (12) cycle();
        chk_q("t5 grants", gnt_addrs,
              '{32'h500, 32'h504, 32'h508, 32'h50C, 32'h600, 32'h604, 32'h608});
        chk_q("t5 pcs", got_pc, '{32'h500, 32'h600, 32'h604, 32'h608});

        // ---- async reset mid-stream ----
        lat = 3; ready_ctl = 1'b0; clear_logs();
        redirect_at(32'h700, 5);
        repeat (5) cycle();
        chk("t6 valid before reset", 32'(InstrValid), 32'd1);
        rst_ctl = 1'b1; reset = 1'b1; IMemRValid = 1'b0;
        model_reset();
        #1;
        chk("t6 async InstrValid", 32'(InstrValid), 32'd0);
        chk("t6 async IMemReq",    32'(IMemReq),    32'd0);
        chk("t6 async Instr",      Instr,           32'd0);
        chk("t6 async InstrPC",    InstrPC,         32'd0);
        chk("t6 async PCPlus8",    PCPlus8,         32'd8);
        repeat (2) cycle();
        clear_logs(); lat = 1; ready_ctl = 1'b1; gnt_budget = 2; rst_ctl = 1'b0;
        cycle(); rel = cyc;
        repeat (8) cycle();
        chk_q("t6 grants", gnt_addrs, '{32'h8000, 32'h8004});
        chk_q("t6 pcs",    got_pc,    '{32'h8000, 32'h8004});
        if (got_cyc.size() > 0) chk("t6 first valid cycle", 32'(got_cyc[0] - rel), 32'd2);

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage: produces the instruction stream that the decode block consumes.
- Holds the PC, issues word reads to instruction memory over a request/grant bus, and buffers in-order responses in a prefetch FIFO.
- Presents the head instruction to decode with a valid/ready handshake, already split into decode fields (Op, Funct, Rd).
- On a redirect (branch taken or a PC write, i.e. PCS resolved), flushes all buffered and in-flight instructions.

Parameters:
- DEPTH, 4, prefetch FIFO entries; also the cap on buffered plus outstanding requests; power of two, at least 2.
- RESET_PC, 32'h00000000, PC value loaded at reset.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- IMemReq  out  1  read request valid
- IMemAddr  out  32  byte address of the request, word aligned
- IMemGnt  in  1  memory accepts the request this cycle
- IMemRValid  in  1  read data valid; responses return in request order
- IMemRData  in  32  read data
- Redirect  in  1  flush and restart fetch
- RedirectPC  in  32  new fetch address; bits [1:0] are ignored and forced to 0
- InstrValid  out  1  head instruction valid
- InstrReady  in  1  decode consumes the head instruction
- Instr  out  32  head instruction word
- InstrPC  out  32  address of the head instruction
- PCPlus8  out  32  InstrPC + 8, modulo 2^32
- Op  out  2  Instr[27:26]
- Funct  out  6  Instr[25:20]
- Rd  out  4  Instr[15:12]

Behaviour:
- Reset (async assert, any time including mid-operation):
  - FetchPC <= RESET_PC; FIFO empty; outstanding count = 0; drop count = 0.
  - IMemReq = 0, InstrValid = 0; Instr, InstrPC, Op, Funct and Rd read 0; PCPlus8 reads 8.
- Credit rule: IMemReq = !Redirect && (occupancy + outstanding < DEPTH). IMemAddr = FetchPC.
- Request handshake:
  - A request completes when IMemReq && IMemGnt. FetchPC then advances by 4, wrapping modulo 2^32, and outstanding increments.
  - While ungranted, IMemReq stays asserted and IMemAddr stays stable. The only exception is Redirect, which withdraws the request in that cycle.
- Response handling (IMemRValid):
  - Outstanding decrements.
  - If drop > 0: drop decrements and the data is discarded.
  - Otherwise {data, address} is pushed into the FIFO. Each FIFO entry records its own PC, taken from an address queue of depth DEPTH.
- Output timing:
  - Outputs are registered from the FIFO head; there is no same-cycle bypass.
  - A response that arrives in cycle t is visible on InstrValid in cycle t+1.
  - With a 1-cycle memory (grant in cycle 0, RValid in cycle 1), the first InstrValid after reset release is in cycle 2.
- Pop: happens when InstrValid && InstrReady. The next entry appears in the following cycle.
- Sustained throughput: 1 instruction per cycle once the FIFO is non-empty.
- Simultaneous push and pop: occupancy is unchanged. This holds when full as well, because the credit rule guarantees a push never targets a full FIFO.
- Redirect in cycle t:
  - FIFO cleared, InstrValid = 0 from t+1.
  - FetchPC <= {RedirectPC[31:2], 2'b00}.
  - drop <= outstanding after the cycle-t grant. A grant and a response in cycle t are both counted; a response in cycle t is itself discarded.
  - No request is issued in cycle t. A request to the new PC may issue from t+1.
  - A pop in the same cycle is ignored: the redirect wins.
- Back-to-back redirects: the latest one wins. The drop count accumulates correctly because it always equals the outstanding count at the latest redirect.
- Error conditions (assertions in the bench): an IMemRValid with outstanding = 0 is illegal; occupancy must never exceed DEPTH.
- Op, Funct and Rd are pure slices of the registered Instr.

Test Plan:
- Reset release with 1-cycle memory returning word = address: IMemAddr sequence 0,4,8,...; InstrValid first high in cycle 2 with Instr=0, InstrPC=0, PCPlus8=8; with InstrReady=1, exactly one instruction per cycle thereafter.
- InstrReady=0 permanently, DEPTH=4: exactly 4 grants, then IMemReq=0; the FIFO holds PCs 0,4,8,12. Raising InstrReady pops them in order and fetching resumes at 16.
- Instr=32'hE0912003 at head: Op=2'b00, Funct=6'b001001, Rd=4'h2.
- Two requests outstanding (memory latency 3) when Redirect with RedirectPC=32'h101 fires: the next IMemAddr is 32'h100; the two late responses are dropped; the first InstrValid shows InstrPC=32'h100.
- Redirect in the same cycle as a pop and an incoming response: nothing from the old stream ever appears; drop count and occupancy are both correct afterwards.
- Reset asserted mid-stream with a request outstanding: outputs clear immediately (async); after release, fetch restarts at RESET_PC (parameter overridden to 32'h8000).
